instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Inverse of the control decoder: turns per-instruction field commands into 32-bit MIPS words.
- Writes the words sequentially into the Harvard instruction memory, then releases the CPU.
- Sits between the testbench/host loader port and the imem write port.
- Covers exactly the instruction subset the core decodes: ADDU, JR, LW, SW, ADDIU, and HALT (opcode 0x3F).

Parameters:
ADDR_W, 8, imem word-address width
DEPTH, 256, max words loadable (must be <= 2**ADDR_W)
BASE_ADDR, 0, first imem word address written

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse: begin a new load session (ignored unless IDLE/DONE/ERR)
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready at clk edge
cmd_kind  in  3  0=ADDU 1=JR 2=LW 3=SW 4=ADDIU 5=HALT, 6/7 illegal
cmd_rs  in  5  rs field
cmd_rt  in  5  rt field
cmd_rd  in  5  rd field (ADDU only)
cmd_imm  in  16  immediate (LW/SW/ADDIU only)
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded instruction
word_count  out  ADDR_W+1  words written this session
busy  out  1  state==LOAD
cpu_release  out  1  high in DONE; drives core out of reset
err  out  1  high in ERR

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; word_count=0; cmd_ready=0; cpu_release=0; err=0. Reset mid-LOAD abandons the session; a write registered on that edge is suppressed.
- States: IDLE, LOAD, DONE, ERR.
  - IDLE/DONE/ERR + start -> LOAD. Clears word_count, ptr=BASE_ADDR, err=0, cpu_release=0.
  - LOAD + accepted HALT -> DONE, after the HALT word is written.
  - LOAD + accepted illegal kind -> ERR. No write.
  - LOAD + word_count==DEPTH with no HALT yet -> ERR on the next edge.
- cmd_ready = (state==LOAD) && (word_count<DEPTH). Combinational from state only, never from cmd_valid.
- Latency: command accepted at edge N -> imem_we=1 with registered addr/wdata for exactly the cycle after edge N. Back-to-back accepts give consecutive strobes. Throughput is 1 word/cycle.
- Address: imem_addr = BASE_ADDR + word_count at accept. ptr increments mod 2**ADDR_W, so wrap past the top is allowed only if DEPTH permits. word_count increments on every legal accept, including HALT.
- Encoding (fields MSB->LSB):
  - ADDU: 000000,rs,rt,rd,00000,100001
  - JR: 000000,rs,15'b0,001000
  - LW: 100011,rs,rt,imm
  - SW: 101011,rs,rt,imm
  - ADDIU: 001001,rs,rt,imm
  - HALT: 111111,26'b0
  - Unused input fields are ignored; they are not encoded.
- start asserted while in LOAD: ignored.
- cmd_valid while not LOAD: no accept, no state change.
- DONE holds cpu_release=1 until start or reset. ERR holds err=1 until start or reset.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_ADDIU=6'h09, OP_HALT=6'h3F.
  - funct constants FN_ADDU=6'h21, FN_JR=6'h08.
  - cmd_kind_e enum (3 bits) and enc_state_e enum.
- The core's control decoder uses the same package constants.
- One combinational sub-module instr_pack: kind+fields -> 32-bit word plus illegal flag. It is reusable by the bench as a reference model.

Test Plan:
- start; ADDU rs=1 rt=2 rd=3; HALT -> writes 0x00221821 @0 and 0xFC000000 @1 on consecutive-cycle strobes; DONE, cpu_release=1, word_count=2.
- Back-to-back ADDIU rs=0 rt=5 imm=0x0010; LW rs=4 rt=6 imm=0xFFFC; SW rs=4 rt=6 imm=0x0008; JR rs=31; HALT -> 0x24050010, 0x8C86FFFC, 0xAC860008, 0x03E00008, 0xFC000000 at addrs 0..4, one per cycle, no gaps.
- cmd_kind=6 mid-session after one ADDU -> no second strobe; ERR, err=1, cmd_ready=0; then start -> LOAD, err=0, word_count=0.
- DEPTH=4: four ADDU without HALT -> 4 writes, then ERR on the next edge; cmd_ready=0 once word_count==4.
- rst_n=0 on the edge a command is accepted -> no imem_we the following cycle; all outputs at reset values; cpu_release=0.
- cmd_valid held high in IDLE and DONE with varied fields -> no imem_we, cmd_ready=0, word_count unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and enums used by the instruction stream
// encoder and the core's control decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        K_ADDU  = 3'd0,
        K_JR    = 3'd1,
        K_LW    = 3'd2,
        K_SW    = 3'd3,
        K_ADDIU = 3'd4,
        K_HALT  = 3'd5
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: command kind plus operand fields to one 32-bit MIPS
// word; kinds outside the decoded subset raise illegal and yield zero.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Field assembly per kind; fields a kind does not use are dropped.
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (kind)
            K_ADDU:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_ADDU};
            K_JR:    word = {OP_RTYPE, rs, 15'b000_0000_0000_0000, FN_JR};
            K_LW:    word = {OP_LW, rs, rt, imm};
            K_SW:    word = {OP_SW, rs, rt, imm};
            K_ADDIU: word = {OP_ADDIU, rs, rt, imm};
            K_HALT:  word = {OP_HALT, 26'h000_0000};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Loader that encodes field commands into MIPS words, writes them to the
// instruction memory one per cycle, and releases the CPU once HALT lands.
module instr_stream_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              cpu_release,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    enc_state_e        state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   word_count_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              cpu_release_r;
    logic              err_r;
    logic [31:0]       word_s;
    logic              illegal_s;
    logic              ready_s;
    logic              accept_s;

    instr_pack u_pack (
        .kind    (cmd_kind),
        .rs      (cmd_rs),
        .rt      (cmd_rt),
        .rd      (cmd_rd),
        .imm     (cmd_imm),
        .word    (word_s),
        .illegal (illegal_s)
    );

    // Ready depends only on registered state so the host never sees a loop through cmd_valid.
    always_comb begin
        ready_s  = (state_r == ST_LOAD) && (word_count_r < DEPTH_C);
        accept_s = ready_s && cmd_valid;
    end

    // Session FSM, write pointer and registered imem write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= BASE_C;
            word_count_r  <= '0;
            imem_we_r     <= 1'b0;
            imem_addr_r   <= BASE_C;
            imem_wdata_r  <= 32'h0000_0000;
            cpu_release_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (illegal_s) begin
                            state_r <= ST_ERR;
                            err_r   <= 1'b1;
                        end else begin
                            imem_we_r    <= 1'b1;
                            imem_addr_r  <= ptr_r;
                            imem_wdata_r <= word_s;
                            ptr_r        <= ptr_r + ADDR_W'(1);
                            word_count_r <= word_count_r + (ADDR_W+1)'(1);
                            if (cmd_kind == K_HALT) begin
                                state_r       <= ST_DONE;
                                cpu_release_r <= 1'b1;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end
                    end else if (word_count_r == DEPTH_C) begin
                        // Memory full without a HALT: the program cannot terminate.
                        state_r <= ST_ERR;
                        err_r   <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r       <= ST_LOAD;
                        ptr_r         <= BASE_C;
                        word_count_r  <= '0;
                        cpu_release_r <= 1'b0;
                        err_r         <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = ready_s;
    assign imem_we     = imem_we_r;
    assign imem_addr   = imem_addr_r;
    assign imem_wdata  = imem_wdata_r;
    assign word_count  = word_count_r;
    assign busy        = (state_r == ST_LOAD);
    assign cpu_release = cpu_release_r;
    assign err         = err_r;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized self-checking bench for instr_stream_encoder against a
// behavioural session model; small DEPTH and a high BASE_ADDR exercise wrap.
module tb_instr_stream_encoder;

    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 12;
    localparam int BASE_ADDR = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_kind;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [15:0]       cmd_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              cpu_release;
    logic              err;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Model: 0 idle, 1 loading, 2 done, 3 error
    int          m_state = 0;
    int          m_count = 0;
    int          m_ptr   = BASE_ADDR;
    bit          m_we    = 1'b0;
    int          m_addr  = BASE_ADDR;
    logic [31:0] m_data  = 32'h0;

    instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
        .busy(busy), .cpu_release(cpu_release), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Instruction word built from opcode/field arithmetic.
    function automatic logic [31:0] ref_word(int k, int rs, int rt, int rd, int imm);
        longint w;
        case (k)
            0: w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + 33;
            1: w = longint'(rs) * 2097152 + 8;
            2: w = 35 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
            3: w = 43 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
            4: w = 9 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
            5: w = 63 * 67108864;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic model_edge(input bit st, input bit v, input int k, input int rs, input int rt,
                              input int rd, input int imm, input bit rn);
        m_we = 1'b0;
        if (!rn) begin
            m_state = 0; m_count = 0; m_ptr = BASE_ADDR; m_addr = BASE_ADDR; m_data = 32'h0;
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_count = 0; m_ptr = BASE_ADDR;
            end
        end else if (v && m_count < DEPTH) begin
            if (k > 5) begin
                m_state = 3;
            end else begin
                m_we    = 1'b1;
                m_addr  = m_ptr;
                m_data  = ref_word(k, rs, rt, rd, imm);
                m_ptr   = (m_ptr + 1) % (1 << ADDR_W);
                m_count = m_count + 1;
                if (k == 5) m_state = 2;
            end
        end else if (m_count == DEPTH) begin
            m_state = 3;
        end
    endtask

    task automatic step(input bit st, input bit v, input int k, input int rs, input int rt,
                        input int rd, input int imm, input bit rn);
        start = st; cmd_valid = v; cmd_kind = 3'(k); cmd_rs = 5'(rs); cmd_rt = 5'(rt);
        cmd_rd = 5'(rd); cmd_imm = 16'(imm); rst_n = rn;
        @(negedge clk);
        check_val("cmd_ready", {31'b0, cmd_ready}, {31'b0, (m_state == 1 && m_count < DEPTH)});
        @(posedge clk);
        model_edge(st, v, k, rs, rt, rd, imm, rn);
        #1;
        check_val("imem_we", {31'b0, imem_we}, {31'b0, m_we});
        if (m_we || !rn) begin
            check_val("imem_addr", 32'(imem_addr), 32'(m_addr));
            check_val("imem_wdata", imem_wdata, m_data);
        end
        check_val("word_count", 32'(word_count), 32'(m_count));
        check_val("busy", {31'b0, busy}, {31'b0, (m_state == 1)});
        check_val("cpu_release", {31'b0, cpu_release}, {31'b0, (m_state == 2)});
        check_val("err", {31'b0, err}, {31'b0, (m_state == 3)});
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        // Reset with a command presented.
        step(1'b0, 1'b1, 0, 1, 2, 3, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1, 2, 3, 0, 1'b0);
        check_val("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, 7, 7, 7, 7, 1'b1);

        // ADDU then HALT.
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b1, 0, 1, 2, 3, 16'h5555, 1'b1);
        check_val("addu_lit", imem_wdata, 32'h0022_1821);
        step(1'b0, 1'b1, 5, 9, 9, 9, 16'hFFFF, 1'b1);
        check_val("halt_lit", imem_wdata, 32'hFC00_0000);
        check_val("done_release", {31'b0, cpu_release}, 32'd1);
        check_val("done_count", 32'(word_count), 32'd2);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), 1'b1);
        check_val("done_no_we", {31'b0, imem_we}, 32'd0);

        // Back-to-back mixed session.
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b1, 4, 0, 5, 0, 16'h0010, 1'b1);
        check_val("addiu_lit", imem_wdata, 32'h2405_0010);
        step(1'b0, 1'b1, 2, 4, 6, 0, 16'hFFFC, 1'b1);
        check_val("lw_lit", imem_wdata, 32'h8C86_FFFC);
        step(1'b0, 1'b1, 3, 4, 6, 0, 16'h0008, 1'b1);
        check_val("sw_lit", imem_wdata, 32'hAC86_0008);
        step(1'b0, 1'b1, 1, 31, 3, 3, 16'h1234, 1'b1);
        check_val("jr_lit", imem_wdata, 32'h03E0_0008);
        step(1'b0, 1'b1, 5, 0, 0, 0, 0, 1'b1);
        check_val("halt2_lit", imem_wdata, 32'hFC00_0000);

        // Illegal kind mid-session, then restart.
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b1, 0, 3, 4, 5, 0, 1'b1);
        step(1'b0, 1'b1, 6, 3, 4, 5, 0, 1'b1);
        check_val("illegal_err", {31'b0, err}, 32'd1);
        check_val("illegal_no_we", {31'b0, imem_we}, 32'd0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        check_val("restart_err", {31'b0, err}, 32'd0);
        check_val("restart_count", 32'(word_count), 32'd0);

        // Fill to DEPTH without HALT (pointer wraps past the top).
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 0, i, i + 1, i + 2, 0, 1'b1);
        step(1'b0, 1'b1, 0, 1, 1, 1, 0, 1'b1);
        check_val("overflow_err", {31'b0, err}, 32'd1);
        idle_cycle();

        // Reset on the accepting edge suppresses the write.
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b1, 0, 1, 2, 3, 0, 1'b0);
        check_val("rst_kill_we", {31'b0, imem_we}, 32'd0);
        check_val("rst_kill_rel", {31'b0, cpu_release}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            int r;
            int k;
            r = $urandom_range(0, 19);
            k = (r < 18) ? (r % 5) : ((r == 18) ? 5 : $urandom_range(6, 7));
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), k,
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 65535), ($urandom_range(0, 99) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
